// File: rtl/pkt_buf_pkg.sv
// Shared constants and pointer helpers for the packet ring buffer.
// Pointers carry one extra wrap bit above the array index.
package pkt_buf_pkg;

    localparam int PKT_DATA_W = 8;
    localparam int PKT_DEPTH  = 64;

    // Distance a - b modulo 2^w, for pointers up to 31 bits wide.
    function automatic logic [31:0] ptr_dist(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Single-write / single-read register array with a registered read port.
// No reset: contents and read register power up undefined.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only moves on a pop, so it holds between pops.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/packet_fifo_buffer.sv
// Circular packet FIFO with commit/discard, sticky error flags
// and a registered read port.
module packet_fifo_buffer
    import pkt_buf_pkg::*;
#(
    parameter int DATA_W = PKT_DATA_W,
    parameter int DEPTH  = PKT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int PTR_W  = ADDR_W + 1,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    input  logic              wr_discard,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic [OCC_W-1:0]  avail,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  cmt_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [DATA_W-1:0] ram_q;
    logic              have_data;
    logic              clr;
    logic              wr_ok;
    logic              rd_ok;

    assign occupancy = OCC_W'(ptr_dist(32'(wr_ptr), 32'(rd_ptr), PTR_W));
    assign avail     = OCC_W'(ptr_dist(32'(cmt_ptr), 32'(rd_ptr), PTR_W));
    assign full      = (occupancy == OCC_W'(DEPTH));
    assign empty     = (avail == '0);

    assign clr        = rst | flush;
    assign wr_ok      = wr_en & ~full & ~wr_discard & ~clr;
    assign rd_ok      = rd_en & ~empty & ~clr;
    assign wr_ptr_nxt = wr_ptr + PTR_W'(wr_ok);

    // RAM read register has no reset; mask it until the first pop.
    assign rd_data = have_data ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            have_data <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                have_data <= 1'b1;
            end
            if (rd_en && empty) underflow <= 1'b1;
            if (wr_discard) begin
                wr_ptr <= cmt_ptr;
            end else begin
                wr_ptr <= wr_ptr_nxt;
                if (wr_en && full) overflow <= 1'b1;
                if (wr_commit) cmt_ptr <= wr_ptr_nxt;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

endmodule
